dmem_sync_rsp: RTL
==================

// Module: dmem_sync_rsp
// PURPOSE
//  Parametrised synchronous data memory for the RV32 core's MEM stage; replaces the combinational-read store.
//  Accepts one load/store request per cycle via valid/ready, reads on the clock edge, returns a registered response.
//  Checks alignment and range, and applies RISC-V LB/LH/LW/LBU/LHU extension and SB/SH/SW byte lanes.
// PARAMETERS
//  DEPTH_WORDS  256   number of 32-bit words; power of 2, >=4
//  ADDR_W       32    request address width
//  BASE_ADDR    0     byte address of word 0; requests outside [BASE, BASE+4*DEPTH) fault
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when req_valid && req_ready
//  req_we       in   1       1 = store, 0 = load
//  req_addr     in   ADDR_W  byte address
//  req_funct3   in   3       RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_wdata    in   32      store data, right-aligned
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       response consumed when rsp_valid && rsp_ready
//  rsp_rdata    out  32      load data, extended; 0 for stores and faults
//  rsp_fault    out  2       00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_rdata=0, rsp_fault=00. Memory contents are not reset; they are zero-initialised for simulation only.
//  - req_ready = !rsp_valid || rsp_ready. One request is accepted per cycle at full throughput.
//  - Latency: a request accepted at edge N has its response valid after edge N, i.e. during cycle N+1.
//  - Backpressure: while rsp_valid && !rsp_ready, rsp_* hold stable and no request is accepted.
//  - Fault priority: illegal funct3 > out-of-range > misaligned.
//    Misaligned: H/HU with addr[0]!=0; W with addr[1:0]!=0.
//    Illegal funct3 on a store: anything other than 000/001/010.
//  - Faulting stores do not write memory. Faulting loads return rdata=0. Either way the response is still issued.
//  - Stores write at the accept edge using a 4-bit byte-enable.
//    SB: lane addr[1:0], data wdata[7:0]. SH: lanes {addr[1],0}, data wdata[15:0]. SW: all four lanes.
//    Unselected bytes are unchanged.
//  - Loads read the array at the accept edge. A load accepted the cycle after a store to the same word sees the new data.
//  - A store and a load cannot be accepted in the same cycle, so there is no same-cycle hazard.
//  - Extension is applied to registered raw word + registered addr[1:0]/funct3 in the response stage.
//    Sign extend for 000/001; zero extend for 100/101.
//  - Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check. No wrap-around aliasing.
//  - If rst_n is asserted while a response is pending, the response is dropped (rsp_valid=0). Memory is untouched.
//    A store accepted in the same edge as reset assertion is not guaranteed.
// STRUCTURE
//  Shared package rv_mem_pkg:
//    funct3 localparams F3_B/H/W/BU/HU; fault codes FLT_OK/MISAL/RANGE/ILL; function be_from_f3(funct3, addr[1:0]) -> [3:0].
//  Sub-module dmem_bank: 1R1W synchronous RAM with 4-bit byte-enable write and registered read; maps to block RAM.
//  Top level holds the handshake, the checks and the response/extension register.
// TESTING
//  1 Reset: rst_n=0 -> rsp_valid=0, req_ready=1. Release, then SW 0xDEADBEEF @0x10 -> rsp_valid next cycle, fault 00.
//  2 Extension: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
//  3 Byte lanes: SB 0x55 @0x11, then LW @0x10 the following cycle -> 0xDEAD55EF, with no stall between store and load.
//  4 Faults: LH @0x01 -> fault 01, rdata 0. SW @4*DEPTH_WORDS -> fault 10, memory unchanged.
//    LW funct3=011 -> fault 11. SW @0x02 -> fault 01 and memory @0x00 unchanged.
//  5 Backpressure: hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_* stable, no extra writes.
//    Release -> back-to-back responses in order.
//  6 Reset mid-operation: assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately.
//    Data stored before reset is readable afterwards.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32 data-memory path.
// Provides funct3 encodings, response fault codes and the store byte-enable helper.
// No ports; imported by dmem_bank users and dmem_sync_rsp.
package rv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] FLT_OK    = 2'b00;
   localparam logic [1:0] FLT_MISAL = 2'b01;
   localparam logic [1:0] FLT_RANGE = 2'b10;
   localparam logic [1:0] FLT_ILL   = 2'b11;

   // Byte lanes touched by an access of the given size at byte offset lo.
   function automatic logic [3:0] be_from_f3(input logic [2:0] funct3, input logic [1:0] lo);
      logic [3:0] be;
      be = 4'b0000;
      case (funct3)
         F3_B, F3_BU: be = 4'b0001 << lo;
         F3_H, F3_HU: be = lo[1] ? 4'b1100 : 4'b0011;
         F3_W:        be = 4'b1111;
         default:     be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Purpose: 1R1W synchronous word RAM, byte-enable write, registered read (block-RAM shaped).
// Latency: read data valid the cycle after i_re; writes land at the same edge.
// Backpressure: none; o_rdata holds its last value while i_re is low.
// Ports: clk; i_we/i_be/i_waddr/i_wdata write port; i_re/i_raddr/o_rdata read port.
module dmem_bank #(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [3:0]       i_be,
   input  logic [IDX_W-1:0] i_waddr,
   input  logic [31:0]      i_wdata,
   input  logic             i_re,
   input  logic [IDX_W-1:0] i_raddr,
   output logic [31:0]      o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   // Array is intentionally not reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_sync_rsp.sv
// Purpose: RV32 MEM-stage data memory with alignment/range/funct3 checks and load extension.
// Latency: request accepted at edge N -> response valid during cycle N+1; full throughput.
// Backpressure: req_ready = !rsp_valid || rsp_ready; a stalled response holds rsp_* stable.
// Ports: clk, rst_n; req_valid/req_ready/req_we/req_addr/req_funct3/req_wdata request side;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_fault response side.
module dmem_sync_rsp
   import rv_mem_pkg::*;
#(
   parameter int                DEPTH_WORDS = 256,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_fault
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic              r_rsp_valid;
   logic              r_we;
   logic [2:0]        r_f3;
   logic [1:0]        r_lo;
   logic [1:0]        r_fault;

   logic              w_accept;
   logic [ADDR_W-2:0] w_diff;
   logic              w_in_range;
   logic [IDX_W-1:0]  w_idx;
   logic              w_f3_legal;
   logic              w_misal;
   logic [1:0]        w_fault;
   logic              w_wr;
   logic              w_rd;
   logic [31:0]       w_wdata;
   logic [31:0]       w_bank_rdata;
   logic [31:0]       w_shift;
   logic [31:0]       w_rdata;

   assign req_ready = !r_rsp_valid || rsp_ready;
   assign w_accept  = req_valid && req_ready;

   // Word offset from BASE with an extra top bit that catches addr < BASE as a borrow.
   // BASE is word aligned, so the byte offset is simply req_addr[1:0].
   assign w_diff     = {1'b0, req_addr[ADDR_W-1:2]} - {1'b0, BASE_ADDR[ADDR_W-1:2]};
   assign w_in_range = (w_diff[ADDR_W-2:IDX_W] == '0);
   assign w_idx      = w_diff[IDX_W-1:0];

   always_comb begin
      w_f3_legal = 1'b0;
      w_misal    = 1'b0;
      case (req_funct3)
         F3_B:        w_f3_legal = 1'b1;
         F3_BU:       w_f3_legal = !req_we;
         F3_H:  begin w_f3_legal = 1'b1;    w_misal = req_addr[0];         end
         F3_HU: begin w_f3_legal = !req_we; w_misal = req_addr[0];         end
         F3_W:  begin w_f3_legal = 1'b1;    w_misal = |req_addr[1:0];      end
         default:     w_f3_legal = 1'b0;
      endcase
   end

   // Priority: illegal funct3, then out-of-range, then misaligned.
   always_comb begin
      if (!w_f3_legal)      w_fault = FLT_ILL;
      else if (!w_in_range) w_fault = FLT_RANGE;
      else if (w_misal)     w_fault = FLT_MISAL;
      else                  w_fault = FLT_OK;
   end

   assign w_wr = w_accept && req_we && (w_fault == FLT_OK);
   assign w_rd = w_accept && !req_we;

   // Replicate store data across lanes; the byte-enable picks the live ones.
   always_comb begin
      case (req_funct3)
         F3_B:    w_wdata = {4{req_wdata[7:0]}};
         F3_H:    w_wdata = {2{req_wdata[15:0]}};
         default: w_wdata = req_wdata;
      endcase
   end

   dmem_bank #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_bank (
      .clk     (clk),
      .i_we    (w_wr),
      .i_be    (be_from_f3(req_funct3, req_addr[1:0])),
      .i_waddr (w_idx),
      .i_wdata (w_wdata),
      .i_re    (w_rd),
      .i_raddr (w_idx),
      .o_rdata (w_bank_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_we        <= 1'b0;
         r_f3        <= 3'b000;
         r_lo        <= 2'b00;
         r_fault     <= FLT_OK;
      end else if (w_accept) begin
         r_rsp_valid <= 1'b1;
         r_we        <= req_we;
         r_f3        <= req_funct3;
         r_lo        <= req_addr[1:0];
         r_fault     <= w_fault;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   // Extension works on the registered raw word; bank and control regs only move on accept,
   // so the response is stable under backpressure.
   assign w_shift = w_bank_rdata >> {r_lo, 3'b000};

   always_comb begin
      w_rdata = '0;
      if (r_rsp_valid && !r_we && (r_fault == FLT_OK)) begin
         case (r_f3)
            F3_B:    w_rdata = {{24{w_shift[7]}},  w_shift[7:0]};
            F3_H:    w_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_BU:   w_rdata = {24'h0, w_shift[7:0]};
            F3_HU:   w_rdata = {16'h0, w_shift[15:0]};
            default: w_rdata = w_shift;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = w_rdata;
   assign rsp_fault = r_fault;

endmodule
